// File: rtl/xenos_xsm_sampler.sv
// XSM channel-status producer: scans NUM_CH channels over a shared ADC port
// (voltage, current, temperature) and publishes one packed word per channel.
module xenos_xsm_sampler #(
  parameter int NUM_CH        = 12,
  parameter int SCAN_INTERVAL = 1000,
  parameter int ADC_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              adc_req,
  output logic [3:0]        adc_ch,
  output logic [1:0]        adc_sel,
  input  logic              adc_ack,
  input  logic [15:0]       adc_data,
  output logic [NUM_CH-1:0] xsm_valid,
  output logic [31:0]       xsm_data [0:NUM_CH-1],
  output logic [NUM_CH-1:0] err_timeout,
  input  logic              err_clear,
  output logic              scan_done,
  output logic              busy
);

  localparam int TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int WW = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(ADC_TIMEOUT - 1);
  localparam logic [WW-1:0] W_LAST  = WW'((SCAN_INTERVAL > 0) ? SCAN_INTERVAL - 1 : 0);
  localparam logic [3:0]    CH_LAST = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, WAIT} state_t;

  state_t            state, state_next;
  logic [3:0]        ch;
  logic [1:0]        sel;
  logic [TW-1:0]     tcnt;
  logic [WW-1:0]     wcnt;
  logic              abort;
  logic [15:0]       volt;
  logic [7:0]        cur;
  logic [NUM_CH-1:0] ch_onehot;
  logic              in_req, got_ack, timeout, req_end, stop, publish, last_ch;

  function automatic logic [7:0] sat8(input logic [15:0] d);
    return (d[15:8] == '0) ? d[7:0] : 8'hFF;
  endfunction

  assign in_req    = (state == REQ);
  assign got_ack   = in_req && adc_ack;
  // an ack on the final allowed cycle takes priority over the timeout
  assign timeout   = in_req && !adc_ack && (tcnt == T_LAST);
  assign req_end   = got_ack || timeout;
  assign stop      = abort || !enable;
  assign publish   = got_ack && (sel == 2'd2) && !stop;
  assign last_ch   = (ch == CH_LAST);
  assign ch_onehot = NUM_CH'(1) << ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = REQ;
      REQ:  if (req_end) state_next = stop ? IDLE : GAP;
      GAP: begin
        if (!enable)                        state_next = IDLE;
        else if (sel != 2'd2 || !last_ch)   state_next = REQ;
        else if (SCAN_INTERVAL == 0)        state_next = REQ;
        else                                state_next = WAIT;
      end
      WAIT: begin
        if (!enable)              state_next = IDLE;
        else if (wcnt == W_LAST)  state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    adc_req   = (state == REQ);
    busy      = (state != IDLE);
    scan_done = (state == GAP) && enable && (sel == 2'd2) && last_ch;
    adc_ch    = ch;
    adc_sel   = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch          <= '0;
      sel         <= '0;
      tcnt        <= '0;
      wcnt        <= '0;
      abort       <= 1'b0;
      volt        <= '0;
      cur         <= '0;
      xsm_valid   <= '0;
      err_timeout <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) xsm_data[i] <= '0;
    end else begin
      xsm_valid   <= '0;
      tcnt        <= (in_req && !req_end) ? tcnt + 1'b1 : '0;
      wcnt        <= (state == WAIT) ? wcnt + 1'b1 : '0;
      abort       <= in_req && !req_end && stop;
      err_timeout <= (err_timeout & ~{NUM_CH{err_clear}}) | (timeout ? ch_onehot : '0);

      if (got_ack) begin
        case (sel)
          2'd0:    volt <= adc_data;
          2'd1:    cur  <= sat8(adc_data);
          default: ;
        endcase
      end
      if (publish) begin
        xsm_data[ch] <= {sat8(adc_data), cur, volt};
        xsm_valid    <= ch_onehot;
      end
      // a timeout skips the rest of the channel by letting GAP see the last quantity
      if (timeout) sel <= 2'd2;

      if (state == IDLE || state_next == IDLE) begin
        ch   <= '0;
        sel  <= '0;
        volt <= '0;
        cur  <= '0;
      end else if (state == GAP) begin
        if (sel != 2'd2) begin
          sel <= sel + 1'b1;
        end else begin
          sel <= '0;
          ch  <= last_ch ? '0 : ch + 1'b1;
        end
      end
    end
  end

endmodule
